// File: rtl/toy_sa_ctrl_pkg.sv
// rtl/toy_sa_ctrl_pkg.sv - shared types and widths for the systolic-array sequencer
package toy_vpack;

  localparam int V_ELEMENT_NUM = 8;
  localparam int SA_OP_WIDTH   = 2;
  localparam int SA_LEN_WIDTH  = 8;

  typedef enum logic [SA_OP_WIDTH-1:0] {
    SA_LOAD = 2'd0,
    SA_MAC  = 2'd1,
    SA_RSV2 = 2'd2,
    SA_RSV3 = 2'd3
  } sa_op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FEED  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } sa_st_e;

endpackage

// File: rtl/toy_sa_ctrl_if.sv
// rtl/toy_sa_ctrl_if.sv - command, beat and array-control bundle between vector core and sequencer
interface toy_sa_ctrl_if
  import toy_vpack::*;
#(
  parameter int N     = V_ELEMENT_NUM,
  parameter int LEN_W = SA_LEN_WIDTH
) ();

  logic                   cmd_vld;
  logic                   cmd_rdy;
  logic [SA_OP_WIDTH-1:0] cmd_op;
  logic [LEN_W-1:0]       cmd_len;
  logic                   in_vld;
  logic                   in_rdy;
  logic [N-1:0]           load_en;
  logic [N-1:0]           shift_en;
  logic [N-1:0]           dout_en;
  logic                   busy;
  logic                   done;
  logic                   err;

  modport master (
    output cmd_vld, cmd_op, cmd_len, in_vld, dout_en,
    input  cmd_rdy, in_rdy, load_en, shift_en, busy, done, err
  );

  modport slave (
    input  cmd_vld, cmd_op, cmd_len, in_vld, dout_en,
    output cmd_rdy, in_rdy, load_en, shift_en, busy, done, err
  );

endinterface

// File: rtl/toy_sa_skew.sv
// rtl/toy_sa_skew.sv - N-stage wavefront delay line; stage i is the injected bit delayed by i+1 cycles
module toy_sa_skew #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_inj,
  input  logic         i_clr,
  output logic [N-1:0] o_stage,
  output logic         o_empty
);

  logic [N-1:0] r_stage;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stage <= '0;
    end else if (i_clr) begin
      r_stage <= '0;
    end else begin
      r_stage <= {r_stage[N-2:0], i_inj};
    end
  end

  assign o_stage = r_stage;
  assign o_empty = ~|r_stage;

endmodule

// File: rtl/toy_sa_ctrl.sv
// rtl/toy_sa_ctrl.sv - systolic-array sequencer: command FSM, beat pacing, skewed enables, result count, drain watchdog
module toy_sa_ctrl
  import toy_vpack::*;
#(
  parameter int N       = V_ELEMENT_NUM,
  parameter int LEN_W   = SA_LEN_WIDTH,
  parameter int TMO_CYC = 64
) (
  input logic          clk,
  input logic          rst_n,
  toy_sa_ctrl_if.slave sa
);

  localparam int             WD_W       = $clog2(TMO_CYC + 1);
  localparam logic [LEN_W:0] LOAD_BEATS = (LEN_W+1)'(N);

  sa_st_e         r_state, w_state_nxt;
  sa_op_e         r_op;
  sa_op_e         w_cmd_op;
  logic [LEN_W:0] r_target, r_beats_left, r_res_cnt, w_cmd_target;
  logic [WD_W-1:0] r_wdog;
  logic           r_err, w_err_nxt;
  logic           w_accept, w_beat, w_result, w_progress, w_exit;
  logic [N-1:0]   w_stage;
  logic           w_empty;

  assign w_cmd_op     = sa_op_e'(sa.cmd_op);
  assign w_cmd_target = (w_cmd_op == SA_LOAD) ? LOAD_BEATS : {1'b0, sa.cmd_len};
  assign w_accept     = sa.cmd_vld && (r_state == ST_IDLE);
  assign w_beat       = (r_state == ST_FEED) && sa.in_vld && (r_beats_left != '0);
  assign w_result     = ((r_state == ST_FEED) || (r_state == ST_DRAIN)) &&
                        (r_op == SA_MAC) && sa.dout_en[N-1];
  // Progress for the watchdog: a bit leaving the skew line or a counted result.
  assign w_progress   = w_stage[N-1] || w_result;
  assign w_exit       = w_empty && ((r_op == SA_LOAD) || (r_res_cnt >= r_target));

  toy_sa_skew #(.N(N)) u_skew (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_inj   (w_beat),
    .i_clr   (w_accept),
    .o_stage (w_stage),
    .o_empty (w_empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_err   <= w_err_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_err_nxt   = r_err;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_err_nxt = 1'b0;
          if ((w_cmd_op == SA_RSV2) || (w_cmd_op == SA_RSV3)) begin
            w_state_nxt = ST_DONE;
            w_err_nxt   = 1'b1;
          end else if (w_cmd_target == '0) begin
            w_state_nxt = ST_DONE;
          end else begin
            w_state_nxt = ST_FEED;
          end
        end
      end
      ST_FEED: begin
        if (w_beat && (r_beats_left == (LEN_W+1)'(1))) w_state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (w_exit) begin
          w_state_nxt = ST_DONE;
          w_err_nxt   = (r_res_cnt > r_target);
        end else if (!w_progress && (r_wdog == WD_W'(TMO_CYC - 1))) begin
          w_state_nxt = ST_DONE;
          w_err_nxt   = 1'b1;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op         <= SA_LOAD;
      r_target     <= '0;
      r_beats_left <= '0;
      r_res_cnt    <= '0;
      r_wdog       <= '0;
    end else begin
      if (w_accept) begin
        r_op         <= w_cmd_op;
        r_target     <= w_cmd_target;
        r_beats_left <= w_cmd_target;
        r_res_cnt    <= '0;
      end else begin
        if (w_beat) r_beats_left <= r_beats_left - 1'b1;
        // Saturate so a runaway array cannot wrap the count back below target.
        if (w_result && (r_res_cnt != '1)) r_res_cnt <= r_res_cnt + 1'b1;
      end
      if ((r_state != ST_DRAIN) || w_progress) r_wdog <= '0;
      else                                    r_wdog <= r_wdog + 1'b1;
    end
  end

  assign sa.cmd_rdy  = (r_state == ST_IDLE);
  assign sa.in_rdy   = (r_state == ST_FEED) && (r_beats_left != '0);
  assign sa.load_en  = (r_op == SA_LOAD) ? w_stage : '0;
  assign sa.shift_en = (r_op == SA_MAC)  ? w_stage : '0;
  assign sa.busy     = (r_state != ST_IDLE);
  assign sa.done     = (r_state == ST_DONE);
  assign sa.err      = (r_state == ST_DONE) && r_err;

endmodule

// File: tb/tb_toy_sa_ctrl.sv
// tb/tb_toy_sa_ctrl.sv - randomized self-checking bench for toy_sa_ctrl against a command-level reference model
module tb_toy_sa_ctrl;
  import toy_vpack::*;

  localparam int NR   = 4;
  localparam int TMO  = 16;
  localparam int MAXK = 256;

  logic clk;
  logic rst_n;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_pass = 0;

  toy_sa_ctrl_if #(.N(NR), .LEN_W(8)) sa_if ();

  toy_sa_ctrl #(.N(NR), .LEN_W(8), .TMO_CYC(TMO)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .sa    (sa_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s at cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
    else n_pass++;
  endtask

  task automatic tick(input logic rn, input logic cv, input logic [1:0] op, input logic [7:0] ln,
                      input logic iv, input logic [NR-1:0] dn,
                      input logic e_cr, input logic e_ir, input logic e_bz, input logic e_dn,
                      input logic e_er, input logic [NR-1:0] e_ld, input logic [NR-1:0] e_sh);
    @(posedge clk);
    #1;
    rst_n           = rn;
    sa_if.cmd_vld   = cv;
    sa_if.cmd_op    = op;
    sa_if.cmd_len   = ln;
    sa_if.in_vld    = iv;
    sa_if.dout_en   = dn;
    @(negedge clk);
    chk("cmd_rdy",  32'(sa_if.cmd_rdy),  32'(e_cr));
    chk("in_rdy",   32'(sa_if.in_rdy),   32'(e_ir));
    chk("busy",     32'(sa_if.busy),     32'(e_bz));
    chk("done",     32'(sa_if.done),     32'(e_dn));
    chk("err",      32'(sa_if.err),      32'(e_er));
    chk("load_en",  32'(sa_if.load_en),  32'(e_ld));
    chk("shift_en", 32'(sa_if.shift_en), 32'(e_sh));
  endtask

  task automatic idle(input logic rn);
    tick(rn, 1'b0, 2'($urandom), 8'($urandom), 1'($urandom), NR'($urandom),
         1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
  endtask

  // Precompute beat/result schedule, predict the completion cycle and err, then play it.
  task automatic run_cmd(input logic [1:0] op, input int len, input int bub_max,
                         input logic [31:0] bub_force, input int res_mode, input int lat_in);
    bit is_beat [MAXK];
    bit is_res  [MAXK];
    int target, k, L, lat, done_k, p, cnt, first, nres, j;
    logic exp_err, feed, cv, iv;
    logic [NR-1:0] dn, en;
    for (int i = 0; i < MAXK; i++) begin
      is_beat[i] = 1'b0;
      is_res[i]  = 1'b0;
    end
    feed = 1'b0; L = 0; done_k = 0; exp_err = 1'b0; target = 0; first = 0;
    if (op >= 2'd2) begin
      done_k = 1; exp_err = 1'b1;
    end else if (op == 2'd1 && len == 0) begin
      done_k = 1; exp_err = 1'b0;
    end else begin
      feed   = 1'b1;
      target = (op == 2'd0) ? NR : len;
      k = 1;
      for (int b = 0; b < target; b++) begin
        k += int'(bub_force[b]) + ((bub_max > 0) ? int'($urandom_range(0, bub_max)) : 0);
        is_beat[k] = 1'b1;
        if (b == 0) first = k;
        L = k;
        k++;
      end
      lat = (lat_in < 0) ? int'($urandom_range(0, 3)) : lat_in;
      if (op == 2'd1) begin
        nres = (res_mode == 1) ? target - 1 : target;
        j = 0;
        for (int c = 1; c <= L; c++) begin
          if (is_beat[c] && j < nres) begin
            is_res[c + NR + lat] = 1'b1;
            j++;
          end
        end
        if (res_mode == 2) is_res[first + NR + lat - 1] = 1'b1;
      end
      p = L;
      for (int kk = L + 1; done_k == 0 && kk < MAXK - 1; kk++) begin
        cnt = 0;
        for (int r = 1; r < kk; r++) cnt += int'(is_res[r]);
        if (kk >= L + NR + 1 && (op == 2'd0 || cnt >= target)) begin
          done_k  = kk + 1;
          exp_err = (op == 2'd1) && (cnt > target);
        end else if ((kk - NR >= 1 && is_beat[kk - NR]) || (op == 2'd1 && is_res[kk])) begin
          p = kk;
        end else if (kk - p == TMO) begin
          done_k  = kk + 1;
          exp_err = 1'b1;
        end
      end
    end
    for (int kk = 0; kk <= done_k; kk++) begin
      cv = (kk == 0) ? 1'b1 : 1'($urandom);
      iv = (feed && kk >= 1 && kk <= L) ? is_beat[kk] : 1'($urandom);
      dn = NR'($urandom);
      if (op == 2'd1 && kk >= 1 && kk < done_k) dn[NR-1] = is_res[kk];
      for (int i = 0; i < NR; i++) en[i] = (kk - 1 - i >= 1) && is_beat[kk - 1 - i];
      tick(1'b1, cv, (kk == 0) ? op : 2'($urandom), (kk == 0) ? 8'(len) : 8'($urandom), iv, dn,
           kk == 0, feed && kk >= 1 && kk <= L, kk >= 1, kk == done_k,
           (kk == done_k) && exp_err,
           (op == 2'd0) ? en : '0, (op == 2'd1) ? en : '0);
    end
  endtask

  initial begin
    int op_r, md_r;
    rst_n = 1'b0;
    sa_if.cmd_vld = 1'b0; sa_if.cmd_op = '0; sa_if.cmd_len = '0;
    sa_if.in_vld = 1'b0; sa_if.dout_en = '0;
    repeat (3) idle(1'b0);
    repeat (2) idle(1'b1);

    run_cmd(2'd0, 0, 0, 32'h0, 0, 0);
    idle(1'b1);
    run_cmd(2'd1, 3, 0, 32'h2, 0, 0);
    idle(1'b1);
    run_cmd(2'd1, 0, 0, 32'h0, 0, 0);
    run_cmd(2'd2, 5, 0, 32'h0, 0, 0);
    run_cmd(2'd1, 2, 0, 32'h0, 1, 0);
    run_cmd(2'd1, 2, 0, 32'h0, 2, 0);
    idle(1'b1);

    // Reset lands while the third of five MAC beats is pending.
    tick(1'b1, 1'b1, 2'd1, 8'd5, 1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
    tick(1'b1, 1'b0, 2'd0, 8'd0, 1'b1, '0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, '0, '0);
    tick(1'b1, 1'b0, 2'd0, 8'd0, 1'b1, '0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, '0, 4'b0001);
    tick(1'b0, 1'b0, 2'd0, 8'd0, 1'b1, '0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
    idle(1'b0);
    repeat (NR + 2) idle(1'b1);
    run_cmd(2'd0, 0, 0, 32'h0, 0, 0);

    run_cmd(2'd0, 0, 0, 32'h0, 0, 0);
    run_cmd(2'd1, 4, 0, 32'h0, 0, 1);

    repeat (30) begin
      op_r = int'($urandom_range(0, 9));
      md_r = int'($urandom_range(0, 5));
      run_cmd((op_r < 4) ? 2'd0 : (op_r < 8) ? 2'd1 : 2'(op_r - 6),
              int'($urandom_range(0, 10)), int'($urandom_range(0, 2)), 32'h0,
              (md_r == 0) ? 1 : (md_r == 1) ? 2 : 0, -1);
      repeat ($urandom_range(0, 2)) idle(1'b1);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/toy_sa_ctrl.md
# toy_sa_ctrl

Systolic-array sequencer between the vector core and the matrix core. It accepts one matrix command at a time, paces vector beats into the array, and generates the diagonally skewed per-row `load_en` and `shift_en` wavefront. It counts results on the last array row and reports completion or error. It replaces ad-hoc enable generation inside the vector core, and the vector core uses it as the single owner of the array's control lines.

## Interface
- `N`, default `V_ELEMENT_NUM` (8): array rows/columns, which is also the skew depth.
- `LEN_W`, default 8: width of the beat-count field.
- `TMO_CYC`, default 64: drain watchdog, in cycles without progress.
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `cmd_vld`  in  1  command valid.
- `cmd_rdy`  out  1  command ready; high only in IDLE.
- `cmd_op`  in  2  `SA_LOAD`=0 (weights), `SA_MAC`=1 (stream inputs); 2 and 3 are illegal.
- `cmd_len`  in  `LEN_W`  number of input vectors for `SA_MAC`; ignored for `SA_LOAD` (always N beats).
- `in_vld`  in  1  a vector beat is presented to the array this cycle.
- `in_rdy`  out  1  controller accepts a beat.
- `load_en`  out  N  per-row weight load enable, bit i = row i.
- `shift_en`  out  N  per-row data shift enable.
- `dout_en`  in  N  per-row result valid from the array; only bit N-1 is counted.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle completion pulse.
- `err`  out  1  qualified by `done`: illegal opcode, watchdog expiry, or result over-count.

## Operation
- States are IDLE, FEED, DRAIN and DONE.
- **IDLE:** `cmd_rdy`=1. A handshake latches `cmd_op` and the beat target (N for LOAD, `cmd_len` for MAC), then moves to:
  - DONE with err=1 if the opcode is illegal;
  - DONE with err=0 if the opcode is MAC and `cmd_len`=0;
  - FEED otherwise.
- **FEED:**
  - `in_rdy` = (beats_left ≠ 0).
  - Each cycle with `in_vld & in_rdy` is a beat. It decrements beats_left and injects a 1 into skew stage 0.
  - A cycle with `in_vld`=0 injects a bubble (0). Bubbles are allowed anywhere in the stream.
  - On the last beat, go to DRAIN.
- **Skew line:** N-stage shift register; stage i is stage 0 delayed by i cycles.
  - `load_en[i]` = stage[i] when op=LOAD, else 0.
  - `shift_en[i]` = stage[i] when op=MAC, else 0.
- **Result count:**
  - res_cnt is `LEN_W`+1 bits, cleared on command accept.
  - It increments on `dout_en[N-1]` in FEED or DRAIN, only when op=MAC.
  - `dout_en` is ignored in IDLE and DONE, and during LOAD.
- **DRAIN:**
  - Exit condition for LOAD: skew line empty.
  - Exit condition for MAC: skew line empty and res_cnt ≥ target.
  - When the exit condition holds, go to DONE. err = (res_cnt > target).
  - Watchdog counter resets on entry and on every skew shift-out or result. Reaching `TMO_CYC` goes to DONE with err=1.
- **DONE:** `done`=1 for one cycle, then IDLE. `dout_en` pulses arriving after DONE are ignored.
- **Reset mid-operation:** all state, counters and skew stages clear immediately. No partial wavefront is emitted after release.

## Timing
- Reset values: `cmd_rdy`=1; all other outputs (`in_rdy`, `load_en`, `shift_en`, `busy`, `done`, `err`) are 0.
- Command handshake at cycle t: state=FEED and `in_rdy`=1 at t+1. For a zero-length or illegal command, `done`=1 at t+1.
- All enable outputs are registered: a beat at cycle b gives `*_en[i]`=1 exactly at cycle b+1+i.
- A LOAD with no bubbles, accepted at t0: beats at t0+1..t0+N. `load_en[N-1]` last high at t0+2N. `done` at t0+2N+2.
- `cmd_rdy` returns high the cycle after `done`. The earliest next command handshake is therefore done+1.
- `in_rdy` drops in the cycle after the last beat. There is no combinational path from `in_vld` to `in_rdy`.

## Structure
- Package `toy_vpack` holds:
  - enum `sa_op_e` (`SA_LOAD`, `SA_MAC`, `SA_RSV2`, `SA_RSV3`);
  - `SA_OP_WIDTH`=2 and `SA_LEN_WIDTH`=8;
  - state enum `sa_st_e`.
- Sub-module `toy_sa_skew`: N-stage wavefront delay line with `inj` input, a synchronous `clr`, and `empty` and `stage[N-1:0]` outputs.
- The top level contains the FSM, beat and result counters, watchdog, and output gating.

## Test plan
- **LOAD, N=4, `in_vld` held high:**
  - Expected `load_en` one-hot diagonal: bit0 at t0+2..t0+5, bit3 at t0+5..t0+8.
  - `shift_en` stays 0; `done` at t0+10 with err=0.
- **MAC, `cmd_len`=3, bubble after beat 1, model returns 3 `dout_en[3]` pulses:**
  - `shift_en` pattern shows a one-cycle gap on every row.
  - `done` pulses with err=0 once the third result and an empty skew line are both reached.
- **MAC, `cmd_len`=0, and `cmd_op`=2:**
  - `done` at t+1 for each; err=0 and err=1 respectively.
  - No `load_en` or `shift_en` activity.
- **MAC, `cmd_len`=2, model returns 1 result:**
  - Watchdog fires `TMO_CYC` cycles after the last progress; `done` with err=1.
  - The same command with 3 results gives err=1 over-count.
- **Reset during FEED, after 2 of 5 beats:**
  - All outputs 0 from the reset-assert cycle; `cmd_rdy`=1 after release.
  - A new LOAD completes normally.
- **Back-to-back commands (LOAD then MAC, `cmd_len`=4):**
  - The second handshake lands at done+1.
  - The second command's `shift_en` never overlaps the first command's `load_en`.
